// File: rtl/cpu_defs.sv
// Shared types for the MEM stage: load kinds, coprocessor/TLB ops and the
// packets exchanged with pre_MEM, WB and the ID forwarding network.
package cpu_defs;

  typedef enum logic [2:0] {LB, LBU, LH, LHU, LW, LWL, LWR} load_op_t;
  typedef enum logic [1:0] {C0_NONE, C0_MFC0, C0_MTC0, C0_ERET} c0_op_t;
  typedef enum logic [1:0] {TLB_NONE, TLB_TLBP, TLB_TLBR, TLB_TLBWI} tlb_op_t;

  typedef struct packed {
    logic        ex;
    logic        bd;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
  } exception_t;

  typedef struct packed {
    logic eret;
    logic ex;
  } pipeline_flush_t;

  typedef struct packed {
    logic        req_ok;
    logic        res_from_mem;
    logic        res_to_mem;
    load_op_t    load_op;
    logic [1:0]  mem_addr_lo;
    logic [31:0] rt_value;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
    exception_t  exception;
    c0_op_t      c0_op;
    logic [7:0]  c0_addr;
    tlb_op_t     tlb_op;
  } pms_payload_t;

  typedef struct packed {
    logic         valid;
    pms_payload_t payload;
  } pms_to_ms_bus_t;

  typedef struct packed {
    logic        valid;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
    exception_t  exception;
    c0_op_t      c0_op;
    logic [7:0]  c0_addr;
    tlb_op_t     tlb_op;
  } ms_to_ws_bus_t;

  typedef struct packed {
    logic        op_mfc0;
    logic        data_pending;
    logic        op_tlb;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_forward_bus_t;

  function automatic logic is_flush(input pipeline_flush_t f);
    return f.eret | f.ex;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: byte/half extraction with sign or zero extension and
// the unaligned LWL/LWR merge against the old rt value.
module load_align
  import cpu_defs::*;
(
  input  load_op_t    load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] rt_value,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (load_op)
      LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LBU: result = {24'd0, byte_sel};
      LH:  result = {{16{half_sel[15]}}, half_sel};
      LHU: result = {16'd0, half_sel};
      LW:  result = word;
      LWL: begin
        case (addr_lo)
          2'd0: result = {word[7:0],  rt_value[23:0]};
          2'd1: result = {word[15:0], rt_value[15:0]};
          2'd2: result = {word[23:0], rt_value[7:0]};
          default: result = word;
        endcase
      end
      LWR: begin
        case (addr_lo)
          2'd1: result = {rt_value[31:24], word[31:8]};
          2'd2: result = {rt_value[31:16], word[31:16]};
          2'd3: result = {rt_value[31:8],  word[31:24]};
          default: result = word;
        endcase
      end
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data,
// forwards to ID and drops responses that belong to flushed requests.
module mem_stage
  import cpu_defs::*;
#(
  parameter int DISCARD_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ws_allowin,
  output logic            ms_allowin,
  input  pms_to_ms_bus_t  pms_to_ms_bus,
  output ms_to_ws_bus_t   ms_to_ws_bus,
  output ms_forward_bus_t ms_forward_bus,
  input  pipeline_flush_t pipeline_flush,
  input  logic            wr_disable,
  output logic            ms_wr_disable,
  input  logic [31:0]     data_rdata,
  input  logic            data_data_ok
);

  logic                 ms_valid;
  pms_payload_t         ms_data;
  logic [DISCARD_W-1:0] discard_cnt;
  logic [31:0]          rdata_buf;
  logic                 rdata_buf_valid;

  logic        flush;
  logic        need_data;
  logic        data_hit;
  logic        ms_ready_go;
  logic        ms_leave;
  logic        cnt_inc;
  logic        cnt_dec;
  logic        keep_rf_we;
  logic [31:0] load_word;
  logic [31:0] aligned;
  logic [31:0] final_result;

  assign flush       = is_flush(pipeline_flush);
  assign need_data   = ms_valid & ms_data.req_ok & (ms_data.res_from_mem | ms_data.res_to_mem);
  assign data_hit    = data_data_ok & (discard_cnt == '0);
  assign ms_ready_go = ~need_data | data_hit | rdata_buf_valid;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_leave    = ms_valid & ms_ready_go & ws_allowin;

  // A flush that strands an outstanding request leaves one response to drop.
  assign cnt_inc = flush & need_data & ~data_hit & ~rdata_buf_valid;
  assign cnt_dec = data_data_ok & (discard_cnt != '0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= pms_to_ms_bus.valid;
    end
  end

  // NOTE: pure datapath registers carry no reset; their contents are qualified by a valid bit.
  always_ff @(posedge clk) begin
    if (pms_to_ms_bus.valid && ms_allowin) begin
      ms_data <= pms_to_ms_bus.payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      discard_cnt <= '0;
    end else if (cnt_inc && !cnt_dec && !(&discard_cnt)) begin
      discard_cnt <= discard_cnt + DISCARD_W'(1);
    end else if (cnt_dec && !cnt_inc) begin
      discard_cnt <= discard_cnt - DISCARD_W'(1);
    end
  end

  // Hold a response that arrives while WB is stalled; a flush must not let it
  // leak into the next packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf_valid <= 1'b0;
    end else if (flush || ms_leave) begin
      rdata_buf_valid <= 1'b0;
    end else if (ms_valid && data_hit) begin
      rdata_buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ms_valid && data_hit && !ms_leave) begin
      rdata_buf <= data_rdata;
    end
  end

  assign load_word = rdata_buf_valid ? rdata_buf : data_rdata;

  load_align u_load_align (
    .load_op  (ms_data.load_op),
    .addr_lo  (ms_data.mem_addr_lo),
    .word     (load_word),
    .rt_value (ms_data.rt_value),
    .result   (aligned)
  );

  assign final_result = (ms_data.res_from_mem && !ms_data.exception.ex) ? aligned : ms_data.result;
  assign keep_rf_we   = ms_valid & ms_data.rf_we & ~ms_data.exception.ex;

  // An older instruction in WB is trapping or returning; this one must not commit.
  always_comb begin
    ms_to_ws_bus              = '0;
    ms_to_ws_bus.valid        = ms_valid & ms_ready_go;
    ms_to_ws_bus.rf_we        = keep_rf_we & ~wr_disable;
    ms_to_ws_bus.dest         = ms_data.dest;
    ms_to_ws_bus.final_result = final_result;
    ms_to_ws_bus.pc           = ms_data.pc;
    ms_to_ws_bus.exception    = ms_data.exception;
    ms_to_ws_bus.c0_op        = ms_data.c0_op;
    ms_to_ws_bus.c0_addr      = ms_data.c0_addr;
    ms_to_ws_bus.tlb_op       = ms_data.tlb_op;
  end

  always_comb begin
    ms_forward_bus = '0;
    if (ms_valid) begin
      ms_forward_bus.op_mfc0      = (ms_data.c0_op == C0_MFC0);
      ms_forward_bus.data_pending = ms_data.res_from_mem & ~ms_ready_go;
      ms_forward_bus.op_tlb       = (ms_data.tlb_op != TLB_NONE);
      ms_forward_bus.dest         = keep_rf_we ? ms_data.dest : 5'd0;
      ms_forward_bus.final_result = final_result;
    end
  end

  assign ms_wr_disable = ms_valid & ms_data.exception.ex;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected WB packets,
// one task per scenario, inline comparisons on stall/flush behaviour.
module tb_mem_stage;
  import cpu_defs::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            ws_allowin;
  logic            ms_allowin;
  pms_to_ms_bus_t  pms_to_ms_bus;
  ms_to_ws_bus_t   ms_to_ws_bus;
  ms_forward_bus_t ms_forward_bus;
  pipeline_flush_t pipeline_flush;
  logic            wr_disable;
  logic            ms_wr_disable;
  logic [31:0]     data_rdata;
  logic            data_data_ok;

  int checks = 0;
  int errors = 0;
  int pc_seq = 0;

  typedef struct {
    logic [31:0] result;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic        ex;
  } exp_t;

  exp_t sb[$];

  mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ws_allowin     (ws_allowin),
    .ms_allowin     (ms_allowin),
    .pms_to_ms_bus  (pms_to_ms_bus),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .ms_forward_bus (ms_forward_bus),
    .pipeline_flush (pipeline_flush),
    .wr_disable     (wr_disable),
    .ms_wr_disable  (ms_wr_disable),
    .data_rdata     (data_rdata),
    .data_data_ok   (data_data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(dut.cnt_inc && (&dut.discard_cnt)))
        else $error("discard counter overflow");
    end
  end

  // WB side: every accepted packet is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ms_to_ws_bus.valid && ws_allowin) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got result=%h pc=%h, expected no packet",
                 ms_to_ws_bus.final_result, ms_to_ws_bus.pc);
      end else begin
        e = sb.pop_front();
        if (ms_to_ws_bus.final_result !== e.result || ms_to_ws_bus.rf_we !== e.rf_we ||
            ms_to_ws_bus.dest !== e.dest || ms_to_ws_bus.pc !== e.pc ||
            ms_to_ws_bus.exception.ex !== e.ex) begin
          errors++;
          $display("FAIL wb_packet: got rf_we=%0b dest=%0d result=%h pc=%h ex=%0b, expected rf_we=%0b dest=%0d result=%h pc=%h ex=%0b",
                   ms_to_ws_bus.rf_we, ms_to_ws_bus.dest, ms_to_ws_bus.final_result,
                   ms_to_ws_bus.pc, ms_to_ws_bus.exception.ex,
                   e.rf_we, e.dest, e.result, e.pc, e.ex);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] next_pc();
    pc_seq++;
    return 32'hBFC0_0000 + 32'(pc_seq * 4);
  endfunction

  function automatic logic [31:0] ref_align(input load_op_t op, input logic [1:0] a,
                                            input logic [31:0] w, input logic [31:0] rt);
    logic [31:0] b8;
    logic [31:0] h16;
    b8  = w >> (8 * a);
    h16 = w >> (16 * a[1]);
    case (op)
      LB:  return {{24{b8[7]}}, b8[7:0]};
      LBU: return {24'd0, b8[7:0]};
      LH:  return {{16{h16[15]}}, h16[15:0]};
      LHU: return {16'd0, h16[15:0]};
      LWL: return (w << (8 * (3 - a))) | (rt & (32'hFFFF_FFFF >> (8 * (a + 1))));
      LWR: return (w >> (8 * a)) | (rt & ~(32'hFFFF_FFFF >> (8 * a)));
      default: return w;
    endcase
  endfunction

  function automatic pms_payload_t mk_load(input load_op_t op, input logic [1:0] a,
                                           input logic [31:0] rt, input logic [4:0] dest);
    pms_payload_t p;
    p              = '0;
    p.req_ok       = 1'b1;
    p.res_from_mem = 1'b1;
    p.load_op      = op;
    p.mem_addr_lo  = a;
    p.rt_value     = rt;
    p.rf_we        = 1'b1;
    p.dest         = dest;
    p.result       = 32'h1000_0000 | 32'(a);
    p.pc           = next_pc();
    return p;
  endfunction

  function automatic pms_payload_t mk_alu(input logic [4:0] dest, input logic [31:0] result);
    pms_payload_t p;
    p        = '0;
    p.rf_we  = 1'b1;
    p.dest   = dest;
    p.result = result;
    p.pc     = next_pc();
    return p;
  endfunction

  function automatic exp_t mk_exp(input pms_payload_t p, input logic [31:0] result);
    exp_t e;
    e.result = result;
    e.rf_we  = p.rf_we & ~p.exception.ex;
    e.dest   = p.dest;
    e.pc     = p.pc;
    e.ex     = p.exception.ex;
    return e;
  endfunction

  // Present one packet; returns one cycle after MEM has captured it.
  task automatic send(input pms_payload_t p);
    int n = 0;
    while (!ms_allowin && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!ms_allowin) begin
      errors++;
      $display("FAIL send_timeout: ms_allowin=%0b after %0d cycles, expected 1", ms_allowin, n);
    end
    pms_to_ms_bus.valid   = 1'b1;
    pms_to_ms_bus.payload = p;
    tick();
    pms_to_ms_bus.valid = 1'b0;
  endtask

  task automatic do_load(input load_op_t op, input logic [1:0] a, input logic [31:0] rt,
                         input logic [31:0] w, input int delay, input logic [31:0] expected);
    pms_payload_t p;
    p = mk_load(op, a, rt, 5'(8 + a));
    sb.push_back(mk_exp(p, expected));
    send(p);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checks++;
      if (ms_to_ws_bus.valid !== 1'b0 || ms_forward_bus.data_pending !== 1'b1 ||
          ms_forward_bus.dest !== p.dest) begin
        errors++;
        $display("FAIL load_stall: got valid=%0b pending=%0b dest=%0d, expected 0 1 %0d",
                 ms_to_ws_bus.valid, ms_forward_bus.data_pending, ms_forward_bus.dest, p.dest);
      end
      tick();
    end
    data_data_ok = 1'b1;
    data_rdata   = w;
    tick();
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ms_to_ws_bus.valid !== 1'b0 || ms_forward_bus.dest !== 5'd0 ||
        ms_wr_disable !== 1'b0 || ms_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b fwd_dest=%0d wr_dis=%0b allowin=%0b, expected 0 0 0 1",
               ms_to_ws_bus.valid, ms_forward_bus.dest, ms_wr_disable, ms_allowin);
    end
    checks++;
    if (dut.discard_cnt !== '0 || dut.rdata_buf_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got discard_cnt=%0d buf_valid=%0b, expected 0 0",
               dut.discard_cnt, dut.rdata_buf_valid);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_lw_zero_wait();
    pms_payload_t p;
    p = mk_load(LW, 2'd0, 32'h0, 5'd3);
    sb.push_back(mk_exp(p, 32'hDEAD_BEEF));
    send(p);
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (ms_to_ws_bus.valid !== 1'b1 || ms_allowin !== 1'b1) begin
      errors++;
      $display("FAIL lw_zero_wait: got valid=%0b allowin=%0b, expected 1 1",
               ms_to_ws_bus.valid, ms_allowin);
    end
    tick();
    data_data_ok = 1'b0;
  endtask

  task automatic test_load_align();
    do_load(LB,  2'd3, 32'h0,         32'h8012_3456, 0, 32'hFFFF_FF80);
    do_load(LBU, 2'd3, 32'h0,         32'h8012_3456, 1, 32'h0000_0080);
    do_load(LWL, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'hCCDD_3344);
    for (int o = 0; o < 7; o++) begin
      for (int a = 0; a < 4; a++) begin
        logic [31:0] w;
        logic [31:0] rt;
        w  = $urandom;
        rt = $urandom;
        do_load(load_op_t'(o), 2'(a), rt, w, int'($urandom_range(0, 2)),
                ref_align(load_op_t'(o), 2'(a), w, rt));
      end
    end
  endtask

  task automatic test_buffered();
    pms_payload_t p;
    p = mk_load(LW, 2'd0, 32'h0, 5'd12);
    sb.push_back(mk_exp(p, 32'h1234_5678));
    send(p);
    ws_allowin   = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (ms_allowin !== 1'b0 || ms_to_ws_bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL buf_arrive: got allowin=%0b valid=%0b, expected 0 1",
               ms_allowin, ms_to_ws_bus.valid);
    end
    tick();
    data_data_ok = 1'b0;
    data_rdata   = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ms_allowin !== 1'b0 || dut.rdata_buf_valid !== 1'b1 ||
          ms_to_ws_bus.final_result !== 32'h1234_5678) begin
        errors++;
        $display("FAIL buf_hold: got allowin=%0b buf_valid=%0b result=%h, expected 0 1 12345678",
                 ms_allowin, dut.rdata_buf_valid, ms_to_ws_bus.final_result);
      end
      tick();
    end
    ws_allowin = 1'b1;
    tick();
    checks++;
    if (dut.rdata_buf_valid !== 1'b0 || ms_allowin !== 1'b1) begin
      errors++;
      $display("FAIL buf_release: got buf_valid=%0b allowin=%0b, expected 0 1",
               dut.rdata_buf_valid, ms_allowin);
    end
  endtask

  task automatic test_flush_discard();
    pms_payload_t a_pkt;
    pms_payload_t b_pkt;
    a_pkt = mk_load(LW, 2'd0, 32'h0, 5'd20);
    send(a_pkt);
    pipeline_flush.ex = 1'b1;
    tick();
    pipeline_flush.ex = 1'b0;
    checks++;
    if (dut.discard_cnt !== 2'd1 || dut.ms_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_count: got discard_cnt=%0d ms_valid=%0b, expected 1 0",
               dut.discard_cnt, dut.ms_valid);
    end
    b_pkt = mk_load(LW, 2'd0, 32'h0, 5'd21);
    sb.push_back(mk_exp(b_pkt, 32'h600D_F00D));
    send(b_pkt);
    data_data_ok = 1'b1;
    data_rdata   = 32'h0000_0BAD;
    @(negedge clk);
    checks++;
    if (ms_to_ws_bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_drop: got valid=%0b result=%h, expected valid 0",
               ms_to_ws_bus.valid, ms_to_ws_bus.final_result);
    end
    tick();
    checks++;
    if (dut.discard_cnt !== 2'd0) begin
      errors++;
      $display("FAIL discard_return: got discard_cnt=%0d, expected 0", dut.discard_cnt);
    end
    data_rdata = 32'h600D_F00D;
    tick();
    data_data_ok = 1'b0;
  endtask

  task automatic test_flush_same_cycle();
    pms_payload_t p;
    p = mk_load(LH, 2'd2, 32'h0, 5'd22);
    send(p);
    ws_allowin        = 1'b0;
    pipeline_flush.ex = 1'b1;
    data_data_ok      = 1'b1;
    data_rdata        = 32'h0000_BAD2;
    tick();
    pipeline_flush.ex = 1'b0;
    data_data_ok      = 1'b0;
    ws_allowin        = 1'b1;
    checks++;
    if (dut.discard_cnt !== 2'd0 || dut.ms_valid !== 1'b0 || dut.rdata_buf_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_cycle: got discard_cnt=%0d ms_valid=%0b buf_valid=%0b, expected 0 0 0",
               dut.discard_cnt, dut.ms_valid, dut.rdata_buf_valid);
    end
    do_load(LW, 2'd0, 32'h0, 32'hC0FF_EE00, 1, 32'hC0FF_EE00);
  endtask

  task automatic test_store();
    pms_payload_t p;
    p            = '0;
    p.req_ok     = 1'b1;
    p.res_to_mem = 1'b1;
    p.dest       = 5'd9;
    p.result     = 32'h0000_1000;
    p.pc         = next_pc();
    sb.push_back(mk_exp(p, 32'h0000_1000));
    send(p);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ms_to_ws_bus.valid !== 1'b0 || ms_allowin !== 1'b0 || ms_forward_bus.data_pending !== 1'b0) begin
        errors++;
        $display("FAIL store_wait: got valid=%0b allowin=%0b pending=%0b, expected 0 0 0",
                 ms_to_ws_bus.valid, ms_allowin, ms_forward_bus.data_pending);
      end
      tick();
    end
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
  endtask

  task automatic test_exception();
    pms_payload_t p;
    p                     = '0;
    p.res_from_mem        = 1'b1;
    p.rf_we               = 1'b1;
    p.dest                = 5'd7;
    p.result              = 32'hBADA_DD00;
    p.pc                  = next_pc();
    p.exception.ex        = 1'b1;
    p.exception.excode    = 5'd4;
    p.exception.badvaddr  = 32'hBADA_DD01;
    sb.push_back(mk_exp(p, 32'hBADA_DD00));
    send(p);
    @(negedge clk);
    checks++;
    if (ms_wr_disable !== 1'b1 || ms_to_ws_bus.valid !== 1'b1 || ms_to_ws_bus.rf_we !== 1'b0 ||
        ms_to_ws_bus.exception.excode !== 5'd4) begin
      errors++;
      $display("FAIL exception_pass: got wr_dis=%0b valid=%0b rf_we=%0b excode=%0d, expected 1 1 0 4",
               ms_wr_disable, ms_to_ws_bus.valid, ms_to_ws_bus.rf_we, ms_to_ws_bus.exception.excode);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ms_wr_disable !== 1'b0) begin
      errors++;
      $display("FAIL exception_clear: got wr_dis=%0b, expected 0", ms_wr_disable);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    pms_payload_t p;
    for (int i = 0; i < 4; i++) begin
      p = mk_alu(5'(i + 1), 32'hA5A5_0000 + 32'(i));
      sb.push_back(mk_exp(p, p.result));
      checks++;
      if (ms_allowin !== 1'b1) begin
        errors++;
        $display("FAIL b2b_allowin: got allowin=%0b at packet %0d, expected 1", ms_allowin, i);
      end
      pms_to_ms_bus.valid   = 1'b1;
      pms_to_ms_bus.payload = p;
      tick();
    end
    pms_to_ms_bus.valid = 1'b0;
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    ws_allowin     = 1'b1;
    pms_to_ms_bus  = '0;
    pipeline_flush = '0;
    wr_disable     = 1'b0;
    data_rdata     = '0;
    data_data_ok   = 1'b0;

    test_reset();
    test_lw_zero_wait();
    test_load_align();
    test_buffered();
    test_flush_discard();
    test_flush_same_cycle();
    test_store();
    test_exception();
    test_back_to_back();

    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d packets outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
